// File: rtl/collision_lane_scanner_pkg.sv
// Shared definitions for the lane-collision scanner and the mux it drives.
package collision_lane_scanner_pkg;

    // Defaults shared with the 8:1 lane-collision mux instance.
    localparam int unsigned DATAWIDTH_SELECTOR_DEF = 3;
    localparam int unsigned NUM_LANES_DEF          = 7;

    // Scanner FSM encoding.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SCAN = 2'b01,
        DONE = 2'b10
    } scan_state_e;

endpackage

// File: rtl/collision_lane_scanner_lowest_lane_encoder.sv
// Priority encoder: lowest set bit of a hit vector as a 1-based lane index, 0 when empty.
module lowest_lane_encoder
    import collision_lane_scanner_pkg::*;
#(
    parameter int unsigned NUM_LANES          = NUM_LANES_DEF,
    parameter int unsigned DATAWIDTH_SELECTOR = DATAWIDTH_SELECTOR_DEF
) (
    input  logic [NUM_LANES-1:0]          lanes_i,
    output logic [DATAWIDTH_SELECTOR-1:0] lane_idx_c_o
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        lane_idx_c_o = '0;
        for (int i = int'(NUM_LANES) - 1; i >= 0; i--) begin
            if (lanes_i[i]) begin
                lane_idx_c_o = DATAWIDTH_SELECTOR'(i + 1);
            end
        end
    end

endmodule

// File: rtl/collision_lane_scanner.sv
// Walks the collision mux select through lanes 1..NUM_LANES and publishes the hit vector.
// Optional build macro COLLISION_SCANNER_STICKY_EN: Collision_Out becomes a sticky flag
// cleared by Clear_In; without it Collision_Out tracks only the last scan.
module collision_lane_scanner
    import collision_lane_scanner_pkg::*;
#(
    parameter int unsigned DATAWIDTH_SELECTOR = DATAWIDTH_SELECTOR_DEF,
    parameter int unsigned NUM_LANES          = NUM_LANES_DEF
) (
    input  logic                          CLOCK_50,
    input  logic                          RESET_InLow,
    input  logic                          Start_In,
    input  logic                          Hold_In,
    input  logic                          Clear_In,
    input  logic                          Z_Bit_In,
    output logic [DATAWIDTH_SELECTOR-1:0] Select_Bus_Out,
    output logic [NUM_LANES-1:0]          Lanes_Out,
    output logic                          Collision_Out,
    output logic [DATAWIDTH_SELECTOR-1:0] First_Lane_Out,
    output logic                          Busy_Out,
    output logic                          Done_Out
);

    localparam logic [DATAWIDTH_SELECTOR-1:0] SEL_ONE  = DATAWIDTH_SELECTOR'(1);
    localparam logic [DATAWIDTH_SELECTOR-1:0] SEL_LAST = DATAWIDTH_SELECTOR'(NUM_LANES);

    scan_state_e                   state_q, state_d;
    logic [DATAWIDTH_SELECTOR-1:0] sel_q, sel_d;
    logic [NUM_LANES-1:0]          w_q, w_d;
    logic [NUM_LANES-1:0]          lanes_q, lanes_d;
    logic                          coll_q, coll_d;
    logic [DATAWIDTH_SELECTOR-1:0] first_q, first_d;
    logic                          busy_q, busy_d;
    logic                          done_q, done_d;

    logic                          step_c;
    logic                          last_c;
    logic [NUM_LANES-1:0]          w_merged_c;
    logic [DATAWIDTH_SELECTOR-1:0] hit_idx_c;

    assign step_c = (state_q == SCAN) && !Hold_In;
    assign last_c = step_c && (sel_q == SEL_LAST);

    // Work vector with the current lane's sample merged in.
    always_comb begin
        w_merged_c = w_q;
        for (int i = 0; i < int'(NUM_LANES); i++) begin
            if (sel_q == DATAWIDTH_SELECTOR'(i + 1)) begin
                w_merged_c[i] = Z_Bit_In;
            end
        end
    end

    lowest_lane_encoder #(
        .NUM_LANES          (NUM_LANES),
        .DATAWIDTH_SELECTOR (DATAWIDTH_SELECTOR)
    ) u_lowest_lane_encoder (
        .lanes_i      (w_merged_c),
        .lane_idx_c_o (hit_idx_c)
    );

    // FSM state register.
    always_ff @(posedge CLOCK_50 or negedge RESET_InLow) begin
        if (!RESET_InLow) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (Start_In) state_d = SCAN;
            SCAN:    if (last_c)   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM status outputs, registered alongside the state.
    always_comb begin
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // Select walk, sample collection and result capture at scan completion.
    always_comb begin
        sel_d   = sel_q;
        w_d     = w_q;
        lanes_d = lanes_q;
        first_d = first_q;
        coll_d  = coll_q;
        case (state_q)
            IDLE: begin
                sel_d = '0;
                if (Start_In) begin
                    sel_d = SEL_ONE;
                    w_d   = '0;
                end
            end
            SCAN: begin
                if (step_c) begin
                    w_d = w_merged_c;
                    if (last_c) begin
                        sel_d   = '0;
                        lanes_d = w_merged_c;
                        first_d = hit_idx_c;
                    end else begin
                        sel_d = sel_q + SEL_ONE;
                    end
                end
            end
            default: sel_d = '0;
        endcase
`ifdef COLLISION_SCANNER_STICKY_EN
        // Clear takes effect before the new result is folded in.
        if (Clear_In) coll_d = 1'b0;
        if (last_c)   coll_d = coll_d | (|w_merged_c);
`else
        if (last_c)   coll_d = |w_merged_c;
`endif
    end

`ifndef COLLISION_SCANNER_STICKY_EN
    logic unused_clear_c;
    assign unused_clear_c = Clear_In;
`endif

    // Datapath and output registers.
    always_ff @(posedge CLOCK_50 or negedge RESET_InLow) begin
        if (!RESET_InLow) begin
            sel_q   <= '0;
            w_q     <= '0;
            lanes_q <= '0;
            coll_q  <= 1'b0;
            first_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            sel_q   <= sel_d;
            w_q     <= w_d;
            lanes_q <= lanes_d;
            coll_q  <= coll_d;
            first_q <= first_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Select_Bus_Out = sel_q;
    assign Lanes_Out      = lanes_q;
    assign Collision_Out  = coll_q;
    assign First_Lane_Out = first_q;
    assign Busy_Out       = busy_q;
    assign Done_Out       = done_q;

endmodule
